// File: rtl/viterbi_pkg.sv
// +-- viterbi_pkg : shared types and trellis helpers for the K=3 rate-1/2 codec --+
// +-- rev 1.0                                                                    --+
`default_nettype none

package viterbi_pkg;

    localparam int DEF_METRIC_W = 8;
    localparam int RESET_METRIC = 16;

    typedef logic [1:0]              state_t;
    typedef logic [DEF_METRIC_W-1:0] metric_t;

    // Generators 7 and 5 octal, state = {b[n-1], b[n-2]}
    function automatic logic [1:0] exp_sym(input state_t s, input logic d);
        return {d ^ s[1] ^ s[0], d ^ s[0]};
    endfunction

    function automatic logic [1:0] branch_metric(input logic [1:0] rx, input logic [1:0] expct);
        logic [1:0] x;
        x = rx ^ expct;
        return {1'b0, x[1]} + {1'b0, x[0]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/viterbi_codec_if.sv
// +-- viterbi_codec_if : encoder and decoder stream signals of the codec --+
// +-- rev 1.0                                                              --+
`default_nettype none

interface viterbi_codec_if;

    logic       enc_enable_i;
    logic       enc_d_i;
    logic       enc_valid_o;
    logic [1:0] enc_d_o;
    logic       dec_enable_i;
    logic [1:0] dec_d_i;
    logic       dec_valid_o;
    logic       dec_d_o;

    modport master (
        output enc_enable_i, enc_d_i, dec_enable_i, dec_d_i,
        input  enc_valid_o, enc_d_o, dec_valid_o, dec_d_o
    );

    modport slave (
        input  enc_enable_i, enc_d_i, dec_enable_i, dec_d_i,
        output enc_valid_o, enc_d_o, dec_valid_o, dec_d_o
    );

endinterface

`default_nettype wire

// File: rtl/conv_encoder_k3.sv
// +-- conv_encoder_k3 : rate-1/2 constraint-length-3 convolutional encoder --+
// +-- rev 1.0                                                                --+
`default_nettype none

module conv_encoder_k3
    import viterbi_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       enable_i,
    input  logic       d_i,
    output logic       valid_o,
    output logic [1:0] sym_o
);

    state_t     state_q, state_d;
    logic [1:0] sym_q, sym_d;
    logic       valid_q;

    always_comb begin
        state_d = state_q;
        sym_d   = sym_q;
        if (enable_i) begin
            sym_d   = exp_sym(state_q, d_i);
            state_d = {d_i, state_q[1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= 2'b00;
            sym_q   <= 2'b00;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sym_q   <= sym_d;
            valid_q <= enable_i;
        end
    end

    assign valid_o = valid_q;
    assign sym_o   = sym_q;

endmodule

`default_nettype wire

// File: rtl/viterbi_acs_unit.sv
// +-- viterbi_acs_unit : add-compare-select for one new trellis state --+
// +-- rev 1.0                                                           --+
`default_nettype none

module viterbi_acs_unit
    import viterbi_pkg::*;
#(
    parameter state_t NEW_STATE = 2'd0,
    parameter int     TB_DEPTH  = 16,
    parameter int     METRIC_W  = 8
) (
    input  logic [1:0]          sym_i,
    input  logic [METRIC_W-1:0] metric0_i,
    input  logic [METRIC_W-1:0] metric1_i,
    input  logic [TB_DEPTH-1:0] surv0_i,
    input  logic [TB_DEPTH-1:0] surv1_i,
    output logic [METRIC_W-1:0] metric_o,
    output logic [TB_DEPTH-1:0] surv_o
);

    localparam int     C_SUM_W = METRIC_W + 1;
    localparam logic   C_D     = NEW_STATE[1];
    localparam state_t C_PRED0 = {NEW_STATE[0], 1'b0};
    localparam state_t C_PRED1 = {NEW_STATE[0], 1'b1};

    logic [C_SUM_W-1:0]  w_cand0, w_cand1;
    logic                w_take1;
    logic [TB_DEPTH-1:0] w_surv_sel;

    assign w_cand0 = {1'b0, metric0_i} + C_SUM_W'(branch_metric(sym_i, exp_sym(C_PRED0, C_D)));
    assign w_cand1 = {1'b0, metric1_i} + C_SUM_W'(branch_metric(sym_i, exp_sym(C_PRED1, C_D)));

    // Strict compare so a tie keeps the s0=0 predecessor
    assign w_take1    = (w_cand1 < w_cand0);
    assign metric_o   = w_take1 ? w_cand1[METRIC_W-1:0] : w_cand0[METRIC_W-1:0];
    assign w_surv_sel = w_take1 ? surv1_i : surv0_i;
    assign surv_o     = (w_surv_sel << 1) | TB_DEPTH'(C_D);

endmodule

`default_nettype wire

// File: rtl/viterbi_codec.sv
// +-- viterbi_codec : K=3 rate-1/2 encoder plus hard-decision Viterbi decoder --+
// +-- rev 1.0                                                                   --+
`default_nettype none

module viterbi_codec
    import viterbi_pkg::*;
#(
    parameter int TB_DEPTH = 16,
    parameter int METRIC_W = DEF_METRIC_W
) (
    input  logic            clk,
    input  logic            rst,
    viterbi_codec_if.slave  bus
);

    localparam int                  C_CNT_W   = $clog2(TB_DEPTH + 1);
    localparam logic [C_CNT_W-1:0]  C_CNT_MAX = C_CNT_W'(TB_DEPTH);
    localparam logic [METRIC_W-1:0] C_RST_M   = METRIC_W'(RESET_METRIC);

    logic [METRIC_W-1:0] metric_q [4];
    logic [METRIC_W-1:0] metric_d [4];
    logic [TB_DEPTH-1:0] surv_q   [4];
    logic [METRIC_W-1:0] w_acs_metric [4];
    logic [TB_DEPTH-1:0] w_acs_surv   [4];
    logic [C_CNT_W-1:0]  cnt_q;
    logic                dec_d_q, dec_valid_q;
    logic                w_all_msb;
    state_t              w_best;

    conv_encoder_k3 u_enc (
        .clk      (clk),
        .rst      (rst),
        .enable_i (bus.enc_enable_i),
        .d_i      (bus.enc_d_i),
        .valid_o  (bus.enc_valid_o),
        .sym_o    (bus.enc_d_o)
    );

    // New state {d, s1} is reached from {s1, 0} and {s1, 1}
    for (genvar g = 0; g < 4; g++) begin : g_acs
        localparam int P0 = (g % 2) * 2;
        viterbi_acs_unit #(
            .NEW_STATE (state_t'(g)),
            .TB_DEPTH  (TB_DEPTH),
            .METRIC_W  (METRIC_W)
        ) u_acs (
            .sym_i     (bus.dec_d_i),
            .metric0_i (metric_q[P0]),
            .metric1_i (metric_q[P0 + 1]),
            .surv0_i   (surv_q[P0]),
            .surv1_i   (surv_q[P0 + 1]),
            .metric_o  (w_acs_metric[g]),
            .surv_o    (w_acs_surv[g])
        );
    end

    always_comb begin
        w_all_msb = 1'b1;
        for (int i = 0; i < 4; i++) w_all_msb &= w_acs_metric[i][METRIC_W-1];
        for (int i = 0; i < 4; i++) begin
            metric_d[i] = w_acs_metric[i];
            if (w_all_msb) metric_d[i][METRIC_W-1] = 1'b0;
        end
    end

    // Pre-update minimum; lowest index wins ties
    always_comb begin
        w_best = 2'd0;
        for (int i = 1; i < 4; i++) begin
            if (metric_q[i] < metric_q[w_best]) w_best = state_t'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            metric_q[0] <= '0;
            metric_q[1] <= C_RST_M;
            metric_q[2] <= C_RST_M;
            metric_q[3] <= C_RST_M;
            for (int i = 0; i < 4; i++) surv_q[i] <= '0;
            cnt_q       <= '0;
            dec_d_q     <= 1'b0;
            dec_valid_q <= 1'b0;
        end else if (bus.dec_enable_i) begin
            metric_q    <= metric_d;
            surv_q      <= w_acs_surv;
            dec_d_q     <= surv_q[w_best][TB_DEPTH-1];
            dec_valid_q <= (cnt_q == C_CNT_MAX);
            if (cnt_q != C_CNT_MAX) cnt_q <= cnt_q + C_CNT_W'(1);
        end else begin
            dec_valid_q <= 1'b0;
        end
    end

    assign bus.dec_d_o     = dec_d_q;
    assign bus.dec_valid_o = dec_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_viterbi_codec.sv
// +-- tb_viterbi_codec : randomized loopback bench with a bit-level reference model --+
// +-- rev 1.0                                                                         --+
`default_nettype none

module tb_viterbi_codec;
    import viterbi_pkg::*;

    localparam int TB_DEPTH = 16;
    localparam int METRIC_W = 8;
    localparam int N_BITS   = 256;

    logic clk;
    logic rst;

    viterbi_codec_if bus ();

    viterbi_codec #(
        .TB_DEPTH (TB_DEPTH),
        .METRIC_W (METRIC_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    bit         cur [N_BITS];
    logic [1:0] chan_q [$];
    logic       clean_dec [$];

    logic [1:0] exp_enc_sym;
    logic       exp_enc_valid;
    logic       exp_dec_d;
    logic       exp_dec_valid;
    int         sent, pushed, acc, n_dec;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, expv, $time);
    endtask

    // Reference encoder straight from the generator polynomials on the bit history
    function automatic logic [1:0] ref_sym(input int i);
        bit b0, b1, b2;
        b0 = cur[i];
        b1 = (i > 0) ? cur[i-1] : 1'b0;
        b2 = (i > 1) ? cur[i-2] : 1'b0;
        return {b0 ^ b1 ^ b2, b0 ^ b2};
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, "_enc_valid"}, 32'(bus.enc_valid_o), 32'(exp_enc_valid));
        chk({tag, "_enc_d"},     32'(bus.enc_d_o),     32'(exp_enc_sym));
        chk({tag, "_dec_valid"}, 32'(bus.dec_valid_o), 32'(exp_dec_valid));
        chk({tag, "_dec_d"},     32'(bus.dec_d_o),     32'(exp_dec_d));
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        bus.enc_enable_i = 1'b0;
        bus.enc_d_i      = 1'b0;
        bus.dec_enable_i = 1'b0;
        bus.dec_d_i      = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst           = 1'b0;
        exp_enc_sym   = 2'b00;
        exp_enc_valid = 1'b0;
        exp_dec_d     = 1'b0;
        exp_dec_valid = 1'b0;
        sent = 0; pushed = 0; acc = 0; n_dec = 0;
        chan_q.delete();
        check_outputs("reset");
    endtask

    task automatic new_stream();
        for (int i = 0; i < N_BITS; i++) cur[i] = bit'($urandom_range(0, 1));
    endtask

    // mode: 0 plain, 1 record decoded bits, 2 compare against recorded bits
    task automatic run_stream(input string tag, input int nbits, input bit gaps,
                              input bit corrupt, input bit drain, input int mode);
        int         budget;
        int         cyc;
        logic [1:0] sym;
        budget = nbits * 8 + 100;
        cyc    = 0;
        while ((sent < nbits || (drain && chan_q.size() > 0)) && cyc < budget) begin
            cyc++;
            bus.enc_enable_i = (sent < nbits) && (!gaps || $urandom_range(0, 3) != 0);
            if (bus.enc_enable_i) begin
                bus.enc_d_i   = cur[sent];
                exp_enc_sym   = ref_sym(sent);
                exp_enc_valid = 1'b1;
                sent++;
            end else begin
                bus.enc_d_i   = 1'($urandom_range(0, 1));
                exp_enc_valid = 1'b0;
            end
            bus.dec_enable_i = (chan_q.size() > 0) && (!gaps || $urandom_range(0, 3) != 0);
            if (bus.dec_enable_i) begin
                bus.dec_d_i   = chan_q.pop_front();
                exp_dec_valid = (acc >= TB_DEPTH);
                if (exp_dec_valid) exp_dec_d = cur[acc - TB_DEPTH];
                acc++;
            end else begin
                bus.dec_d_i   = 2'($urandom_range(0, 3));
                exp_dec_valid = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            check_outputs(tag);
            // Registered channel: flips bit 0 of every 8th symbol when corrupting
            if (bus.enc_valid_o === 1'b1) begin
                sym = bus.enc_d_o;
                if (corrupt && (pushed % 8 == 7)) sym[0] = ~sym[0];
                chan_q.push_back(sym);
                pushed++;
            end
            if (bus.dec_valid_o === 1'b1) begin
                if (mode == 1) clean_dec.push_back(bus.dec_d_o);
                if (mode == 2 && n_dec < clean_dec.size())
                    chk({tag, "_vs_gapfree"}, 32'(bus.dec_d_o), 32'(clean_dec[n_dec]));
                n_dec++;
            end
        end
        bus.enc_enable_i = 1'b0;
        bus.dec_enable_i = 1'b0;
        chk({tag, "_in_budget"}, 32'(cyc < budget), 32'd1);
        chk({tag, "_n_decoded"}, 32'(n_dec), 32'((acc > TB_DEPTH) ? acc - TB_DEPTH : 0));
    endtask

    bit         vec_bits [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [1:0] vec_syms [4] = '{2'b11, 2'b10, 2'b00, 2'b01};

    initial begin
        int v_cnt;
        rst              = 1'b1;
        bus.enc_enable_i = 1'b0;
        bus.enc_d_i      = 1'b0;
        bus.dec_enable_i = 1'b0;
        bus.dec_d_i      = 2'b00;

        do_reset();
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check_outputs("idle");
        end

        // Directed encoder vector
        do_reset();
        v_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            bus.enc_enable_i = 1'b1;
            bus.enc_d_i      = vec_bits[i];
            @(posedge clk);
            @(negedge clk);
            chk("encvec_sym", 32'(bus.enc_d_o), 32'(vec_syms[i]));
            if (bus.enc_valid_o === 1'b1) v_cnt++;
        end
        bus.enc_enable_i = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("encvec_hold", 32'(bus.enc_d_o), 32'(2'b01));
            if (bus.enc_valid_o === 1'b1) v_cnt++;
        end
        chk("encvec_valid_cycles", 32'(v_cnt), 32'd4);

        new_stream();
        do_reset();
        run_stream("clean", N_BITS, 1'b0, 1'b0, 1'b1, 1);

        do_reset();
        run_stream("corrupt", N_BITS, 1'b0, 1'b1, 1'b1, 0);

        do_reset();
        run_stream("gaps", N_BITS, 1'b1, 1'b0, 1'b1, 2);

        do_reset();
        run_stream("pre_reset", 100, 1'b0, 1'b0, 1'b0, 0);
        do_reset();
        new_stream();
        run_stream("restart", N_BITS, 1'b0, 1'b0, 1'b1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d checks", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
